fifo_wr: RTL

FIFO_WR -- requirements
Module: fifo_wr

---
 rtl/fifo_wr.sv | 68 ++++++
 1 files changed

// File: rtl/fifo_wr.sv
// fifo_wr: write side of an async FIFO; Gray pointer sync, full/overflow, level logic under FIFO_WR_LEVEL_EN.
module fifo_wr #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int AFULL_TH = 12
) (
  input  logic          I_WR_CLK,
  input  logic          I_WR_RST,
  input  logic          I_WR_EN,
  input  logic [DW-1:0] I_WR_DATA,
  input  logic [AW:0]   I_WR_RD_PTR,
  input  logic          I_WR_OVF_CLR,
  output logic          O_WR_MEM_WE,
  output logic [DW-1:0] O_WR_MEM_DATA,
  output logic [AW-1:0] O_WR_ADDR,
  output logic [AW:0]   O_WR_PTR,
  output logic          O_WR_FULL,
  output logic          O_WR_ALMOST_FULL,
  output logic [AW:0]   O_WR_LEVEL,
  output logic          O_WR_OVERFLOW
);
  logic [AW:0] wbin, wbin_next, wgray_next, rq1, rq2;
  logic accept;
  assign accept = I_WR_EN & ~O_WR_FULL & ~I_WR_RST;
  assign O_WR_MEM_WE = accept;
  assign O_WR_MEM_DATA = I_WR_DATA;
  assign O_WR_ADDR = wbin[AW-1:0];
  assign wbin_next = wbin + {{AW{1'b0}}, accept};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  always_ff @(posedge I_WR_CLK) begin
    if (I_WR_RST) begin
      wbin <= '0;
      O_WR_PTR <= '0;
      rq1 <= '0;
      rq2 <= '0;
      O_WR_FULL <= 1'b0;
      O_WR_OVERFLOW <= 1'b0;
    end else begin
      rq1 <= I_WR_RD_PTR;
      rq2 <= rq1;
      wbin <= wbin_next;
      O_WR_PTR <= wgray_next;
      // full when write pointer leads read pointer by exactly the depth
      O_WR_FULL <= wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]};
      O_WR_OVERFLOW <= (I_WR_EN & O_WR_FULL) ? 1'b1 : (I_WR_OVF_CLR ? 1'b0 : O_WR_OVERFLOW);
    end
  end
`ifdef FIFO_WR_LEVEL_EN
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_TH);
  logic [AW:0] rbin, level_next;
  for (genvar i = 0; i <= AW; i++) begin : g_g2b
    assign rbin[i] = ^(rq2 >> i);
  end
  assign level_next = wbin_next - rbin;
  always_ff @(posedge I_WR_CLK) begin
    if (I_WR_RST) begin
      O_WR_LEVEL <= '0;
      O_WR_ALMOST_FULL <= 1'b0;
    end else begin
      O_WR_LEVEL <= level_next;
      O_WR_ALMOST_FULL <= level_next >= AF_TH;
    end
  end
`else
  assign O_WR_LEVEL = '0;
  assign O_WR_ALMOST_FULL = O_WR_FULL;
`endif
endmodule
